// File: rtl/nco_rot_multi.sv
// Multi-channel recursive NCO: loads a rotation step and initial phasors from a ROM row,
// then rotates every channel by the step on each accepted ADV. Define NCO_RENORM_EN for periodic amplitude renormalisation.
module nco_rot_multi #(
    parameter int W        = 18,
    parameter int N_CH     = 2,
    parameter int ROW_BITS = 9,
    parameter int RN_LOG2  = 8
) (
    input  logic                                CK,
    input  logic                                RST_N,
    input  logic                                START,
    input  logic [ROW_BITS-1:0]                 ROW,
    input  logic                                ADV,
    output logic                                ADV_RDY,
    output logic [ROW_BITS+$clog2(2*N_CH)-1:0]  rom_addr,
    output logic                                rom_ce,
    input  logic [W-1:0]                        rom_data,
    output logic                                VALID,
    output logic [N_CH*W-1:0]                   cos_o,
    output logic [N_CH*W-1:0]                   sin_o
);
    localparam int WB = $clog2(2*N_CH);
    localparam int XW = 2*W+2;
    localparam logic [WB-1:0] LAST = WB'(2*N_CH-1);
    localparam logic signed [W-1:0]  ONE = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [XW-1:0] HI  = XW'(ONE);

`ifdef NCO_RENORM_EN
    typedef enum logic [1:0] {IDLE, FETCH, RUN, RENORM} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, RUN} state_t;
`endif

    state_t              state;
    logic                cap_vld;
    logic [WB-1:0]       cap_w;
    logic signed [W-1:0] cosd, sind;
    logic signed [W-1:0] cs [N_CH];
    logic signed [W-1:0] sn [N_CH];
    logic signed [W-1:0] rot_c [N_CH];
    logic signed [W-1:0] rot_s [N_CH];

    function automatic logic signed [XW-1:0] ext(input logic signed [W-1:0] x);
        return XW'(x);
    endfunction

    // Clamp to the symmetric range so -2^(W-1) never appears.
    function automatic logic signed [W-1:0] sat(input logic signed [XW-1:0] x);
        if (x > HI)  return ONE;
        if (x < -HI) return -ONE;
        return x[W-1:0];
    endfunction

    always_comb begin
        for (int unsigned k = 0; k < N_CH; k++) begin
            rot_c[k] = sat((ext(cs[k]) * ext(cosd) - ext(sn[k]) * ext(sind)) >>> (W-1));
            rot_s[k] = sat((ext(sn[k]) * ext(cosd) + ext(cs[k]) * ext(sind)) >>> (W-1));
        end
    end

`ifdef NCO_RENORM_EN
    logic [RN_LOG2-1:0]  rn_cnt;
    logic                rn_ph;
    logic [W:0]          g_q   [N_CH];
    logic [W:0]          g_nx  [N_CH];
    logic signed [W-1:0] nrm_c [N_CH];
    logic signed [W-1:0] nrm_s [N_CH];

    // One Newton step towards unit magnitude: g = (3 - |p|^2) / 2.
    function automatic logic [W:0] gain(input logic signed [W-1:0] c, input logic signed [W-1:0] s);
        logic signed [XW-1:0] m;
        logic signed [XW-1:0] g;
        m = (ext(c) * ext(c) + ext(s) * ext(s)) >>> (W-1);
        g = (HI + HI + HI - m) >>> 1;
        return g[W:0];
    endfunction

    always_comb begin
        for (int unsigned k = 0; k < N_CH; k++) begin
            g_nx[k]  = gain(cs[k], sn[k]);
            nrm_c[k] = sat((ext(cs[k]) * XW'($signed({1'b0, g_q[k]}))) >>> (W-1));
            nrm_s[k] = sat((ext(sn[k]) * XW'($signed({1'b0, g_q[k]}))) >>> (W-1));
        end
    end
`endif

    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            ADV_RDY  <= 1'b0;
            VALID    <= 1'b0;
            rom_ce   <= 1'b0;
            rom_addr <= '0;
            cap_vld  <= 1'b0;
            cap_w    <= '0;
            cosd     <= '0;
            sind     <= '0;
            for (int unsigned k = 0; k < N_CH; k++) begin
                cs[k] <= '0;
                sn[k] <= '0;
            end
`ifdef NCO_RENORM_EN
            rn_cnt <= '0;
            rn_ph  <= 1'b0;
            for (int unsigned k = 0; k < N_CH; k++) g_q[k] <= '0;
`endif
        end else begin
            // ROM data on the bus this cycle belongs to the word addressed last cycle.
            cap_vld <= rom_ce;
            cap_w   <= rom_addr[WB-1:0];
            if (START) begin
                state    <= FETCH;
                VALID    <= 1'b0;
                ADV_RDY  <= 1'b0;
                rom_ce   <= 1'b1;
                rom_addr <= {ROW, {WB{1'b0}}};
                cap_vld  <= 1'b0;
`ifdef NCO_RENORM_EN
                rn_cnt <= '0;
                rn_ph  <= 1'b0;
`endif
            end else begin
                unique case (state)
                    FETCH: begin
                        if (rom_ce) begin
                            if (rom_addr[WB-1:0] == LAST) rom_ce <= 1'b0;
                            else rom_addr[WB-1:0] <= rom_addr[WB-1:0] + WB'(1);
                        end
                        if (cap_vld) begin
                            if (cap_w == WB'(0)) cosd <= rom_data;
                            if (cap_w == WB'(1)) sind <= rom_data;
                            for (int unsigned k = 1; k < N_CH; k++) begin
                                if (cap_w == WB'(2*k))   cs[k] <= rom_data;
                                if (cap_w == WB'(2*k+1)) sn[k] <= rom_data;
                            end
                            if (cap_w == LAST) begin
                                cs[0]   <= ONE;
                                sn[0]   <= '0;
                                state   <= RUN;
                                VALID   <= 1'b1;
                                ADV_RDY <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (ADV) begin
                            for (int unsigned k = 0; k < N_CH; k++) begin
                                cs[k] <= rot_c[k];
                                sn[k] <= rot_s[k];
                            end
`ifdef NCO_RENORM_EN
                            rn_cnt <= rn_cnt + RN_LOG2'(1);
                            if (&rn_cnt) begin
                                state   <= RENORM;
                                ADV_RDY <= 1'b0;
                                rn_ph   <= 1'b0;
                            end
`endif
                        end
                    end
`ifdef NCO_RENORM_EN
                    RENORM: begin
                        if (!rn_ph) begin
                            for (int unsigned k = 0; k < N_CH; k++) g_q[k] <= g_nx[k];
                            rn_ph <= 1'b1;
                        end else begin
                            for (int unsigned k = 0; k < N_CH; k++) begin
                                cs[k] <= nrm_c[k];
                                sn[k] <= nrm_s[k];
                            end
                            state   <= RUN;
                            ADV_RDY <= 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_pack
        assign cos_o[k*W +: W] = cs[k];
        assign sin_o[k*W +: W] = sn[k];
    end

endmodule

// File: tb/tb_nco_rot_multi.sv
// Bench for nco_rot_multi: behavioural ROM plus an arithmetic phasor model; random ADV streams over several rows.
module tb_nco_rot_multi;
    localparam int W        = 18;
    localparam int N_CH     = 2;
    localparam int ROW_BITS = 9;
    localparam int WB       = $clog2(2*N_CH);
`ifdef NCO_RENORM_EN
    localparam int RN_LOG2  = 2;
    localparam bit RN_EN    = 1'b1;
`else
    localparam int RN_LOG2  = 8;
    localparam bit RN_EN    = 1'b0;
`endif
    localparam int          ONE_I = (1 << (W-1)) - 1;
    localparam int unsigned RSPAN = 2 * ((1 << (W-1)) - 1);
    localparam longint      ONE   = longint'(ONE_I);
    localparam longint      SC    = longint'(1) << (W-1);

    logic                   CK = 1'b0;
    logic                   RST_N = 1'b0;
    logic                   START = 1'b0;
    logic                   ADV = 1'b0;
    logic [ROW_BITS-1:0]    ROW = '0;
    logic                   ADV_RDY, rom_ce, VALID;
    logic [ROW_BITS+WB-1:0] rom_addr;
    logic [W-1:0]           rom_data = '0;
    logic [N_CH*W-1:0]      cos_o, sin_o;

    logic [W-1:0] rom_mem [1 << (ROW_BITS+WB)];
    longint       mc [N_CH];
    longint       ms [N_CH];
    longint       mcd, msd;
    int unsigned  acc, hold;
    int unsigned  vectors, miscompares;

    nco_rot_multi #(.W(W), .N_CH(N_CH), .ROW_BITS(ROW_BITS), .RN_LOG2(RN_LOG2)) dut (
        .CK(CK), .RST_N(RST_N), .START(START), .ROW(ROW), .ADV(ADV), .ADV_RDY(ADV_RDY),
        .rom_addr(rom_addr), .rom_ce(rom_ce), .rom_data(rom_data), .VALID(VALID),
        .cos_o(cos_o), .sin_o(sin_o)
    );

    always #5 CK = ~CK;

    always @(posedge CK) if (rom_ce) rom_data <= rom_mem[rom_addr];

    function automatic longint fdiv(input longint x, input longint d);
        return (x >= 0) ? x / d : -((-x + d - 1) / d);
    endfunction

    function automatic longint clampv(input longint x);
        return (x > ONE) ? ONE : ((x < -ONE) ? -ONE : x);
    endfunction

    function automatic longint word(input int unsigned r, input int unsigned w);
        logic signed [W-1:0] v;
        v = rom_mem[r*2*N_CH + w];
        return longint'(v);
    endfunction

    function automatic logic [W-1:0] rnd();
        int x;
        x = int'($urandom_range(0, RSPAN)) - ONE_I;
        return W'(x);
    endfunction

    function automatic logic signed [W-1:0] cosk(input int unsigned k);
        return cos_o[k*W +: W];
    endfunction

    function automatic logic signed [W-1:0] sink(input int unsigned k);
        return sin_o[k*W +: W];
    endfunction

    task automatic set_row(input int unsigned r, input int w0, input int w1, input int w2, input int w3);
        rom_mem[r*4+0] = W'(w0);
        rom_mem[r*4+1] = W'(w1);
        rom_mem[r*4+2] = W'(w2);
        rom_mem[r*4+3] = W'(w3);
    endtask

    task automatic model_load(input int unsigned r);
        mcd = word(r, 0);
        msd = word(r, 1);
        mc[0] = ONE;
        ms[0] = 0;
        for (int unsigned k = 1; k < N_CH; k++) begin
            mc[k] = word(r, 2*k);
            ms[k] = word(r, 2*k+1);
        end
        acc  = 0;
        hold = 0;
    endtask

    task automatic model_adv();
        longint c, s;
        for (int unsigned k = 0; k < N_CH; k++) begin
            c = mc[k];
            s = ms[k];
            mc[k] = clampv(fdiv(c*mcd - s*msd, SC));
            ms[k] = clampv(fdiv(s*mcd + c*msd, SC));
        end
    endtask

    task automatic model_renorm();
        longint m, g;
        for (int unsigned k = 0; k < N_CH; k++) begin
            m = fdiv(mc[k]*mc[k] + ms[k]*ms[k], SC);
            g = fdiv(3*ONE - m, 2) & ((longint'(1) << (W+1)) - 1);
            mc[k] = clampv(fdiv(mc[k]*g, SC));
            ms[k] = clampv(fdiv(ms[k]*g, SC));
        end
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag);
        for (int unsigned k = 0; k < N_CH; k++) begin
            chk($sformatf("%s cos%0d", tag, k), cosk(k), mc[k]);
            chk($sformatf("%s sin%0d", tag, k), sink(k), ms[k]);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic do_start(input int unsigned r);
        START = 1'b1;
        ROW   = ROW_BITS'(r);
        tick();
        START = 1'b0;
        ADV   = 1'b0;
        model_load(r);
        for (int unsigned i = 0; i <= 2*N_CH; i++) begin
            if (i < 2*N_CH) begin
                chk("fetch rom_ce", rom_ce, 1);
                chk("fetch rom_addr", rom_addr, r*2*N_CH + i);
            end
            chk("fetch valid", VALID, 0);
            chk("fetch adv_rdy", ADV_RDY, 0);
            tick();
        end
        chk("load valid", VALID, 1);
        chk("load adv_rdy", ADV_RDY, 1);
        chk("load rom_ce", rom_ce, 0);
        chk_outs("load");
    endtask

    task automatic adv_step(input bit a);
        ADV = a;
        tick();
        ADV = 1'b0;
        if (hold > 0) begin
            hold--;
            if (hold == 0) model_renorm();
        end else if (a) begin
            model_adv();
            acc++;
            if (RN_EN && (acc % (1 << RN_LOG2)) == 0) hold = 2;
        end
        chk("run adv_rdy", ADV_RDY, hold == 0);
        chk("run valid", VALID, 1);
        chk_outs("run");
    endtask

    initial begin
        longint mag, lo, hi;
        vectors = 0;
        miscompares = 0;
        acc = 0;
        hold = 0;
        for (int unsigned i = 0; i < (1 << (ROW_BITS+WB)); i++) rom_mem[i] = '0;
        set_row(0, 0, 131071, 92681, 92681);
        set_row(1, -131071, 0, -131071, 0);
        set_row(3, 131071, 131071, -131071, 131071);
        set_row(4, 131051, 2287, 0, 131071);
        for (int unsigned r = 5; r < 10; r++)
            for (int unsigned w = 0; w < 4; w++) rom_mem[r*4+w] = rnd();
        for (int unsigned w = 0; w < 4; w++) rom_mem[2*4+w] = rnd();

        #2;
        chk("reset valid", VALID, 0);
        chk("reset adv_rdy", ADV_RDY, 0);
        chk("reset rom_ce", rom_ce, 0);
        chk("reset rom_addr", rom_addr, 0);
        chk("reset cos_o", cos_o, 0);
        chk("reset sin_o", sin_o, 0);
        repeat (2) tick();
        RST_N = 1'b1;
        repeat (3) tick();
        chk("idle valid", VALID, 0);
        chk("idle adv_rdy", ADV_RDY, 0);
        chk("idle rom_ce", rom_ce, 0);

        do_start(0);
        chk("row0 ch1 cos", cosk(1), 92681);
        adv_step(1'b1);
        chk("quarter cos0", cosk(0), 0);
        chk("quarter sin0", sink(0), 131070);
        adv_step(1'b1);
        chk("half cos0", cosk(0), -131070);
        chk("half sin0", sink(0), 0);
        repeat (3) adv_step(1'b0);
        repeat (20) adv_step(1'($urandom_range(0, 1)));

        ADV = 1'b1;
        do_start(2);
        repeat (30) adv_step(1'($urandom_range(0, 1)));

        do_start(1);
        adv_step(1'b1);
        chk("negstep cos1", cosk(1), 131070);
        chk("negstep sin1", sink(1), 0);
        adv_step(1'b1);

        do_start(3);
        adv_step(1'b1);
        chk("clamp cos1", cosk(1), -131071);
        chk("clamp sin1", sink(1), 0);
        chk("clamp cos0", cosk(0), 131070);
        repeat (3) adv_step(1'b1);

        for (int unsigned r = 5; r < 10; r++) begin
            do_start(r);
            repeat (40) adv_step(1'($urandom_range(0, 1)));
        end

        START = 1'b1;
        ROW   = ROW_BITS'(2);
        tick();
        START = 1'b0;
        repeat (2) tick();
        #1;
        RST_N = 1'b0;
        #1;
        chk("async valid", VALID, 0);
        chk("async adv_rdy", ADV_RDY, 0);
        chk("async rom_ce", rom_ce, 0);
        chk("async rom_addr", rom_addr, 0);
        chk("async cos_o", cos_o, 0);
        chk("async sin_o", sin_o, 0);
        tick();
        RST_N = 1'b1;
        ADV = 1'b1;
        repeat (6) tick();
        ADV = 1'b0;
        chk("post-reset valid", VALID, 0);
        chk("post-reset adv_rdy", ADV_RDY, 0);
        chk("post-reset rom_ce", rom_ce, 0);
        chk("post-reset cos_o", cos_o, 0);

        do_start(4);
        repeat (RN_EN ? 4096 : 256) adv_step(1'b1);
`ifdef NCO_RENORM_EN
        mag = longint'(cosk(0)) * longint'(cosk(0)) + longint'(sink(0)) * longint'(sink(0));
        lo  = ONE*ONE - (ONE*ONE) / 1000;
        hi  = ONE*ONE + (ONE*ONE) / 1000;
        chk("renorm magnitude", (mag >= lo) && (mag <= hi), 1);
`else
        mag = 0;
        lo  = 0;
        hi  = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
